// File: rtl/lightpen_locator.sv
// Light-pen receive path: correlates the synchronized pen detector with the delayed LED scan
// and reports the confirmed pixel under the pen, with pen-down/pen-up debouncing across frames.
module lightpen_locator #(
   parameter int PEN_LAT        = 2,
   parameter int CONFIRM_FRAMES = 2,
   parameter int MISS_FRAMES    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       frame_start,
   input  logic       pix_valid,
   input  logic [2:0] pix_x,
   input  logic [2:0] pix_y,
   input  logic       we,
   output logic [2:0] pos_x,
   output logic [2:0] pos_y,
   output logic       pos_valid,
   output logic       pen_down,
   output logic       pen_up
);

   localparam int         DEPTH     = PEN_LAT + 2;
   localparam logic [3:0] CONFIRM_C = 4'(CONFIRM_FRAMES);
   localparam logic [3:0] MISS_C    = 4'(MISS_FRAMES);

   typedef enum logic [1:0] {ST_UP, ST_ARMING, ST_DOWN} state_t;

   logic       weMeta_q, penS_q;
   logic [7:0] dl_q [DEPTH];

   logic       dFs, dPv, penHit;
   logic [2:0] dX, dY;

   state_t     state_q, state_d;
   logic       frameOpen_q, frameOpen_d;
   logic       hit_q, hit_d;
   logic [2:0] hitX_q, hitX_d, hitY_q, hitY_d;
   logic [2:0] candX_q, candX_d, candY_q, candY_d;
   logic [3:0] cnt_q, cnt_d, miss_q, miss_d;
   logic [2:0] posX_q, posX_d, posY_q, posY_d;
   logic       posValid_q, posValid_d;
   logic       penDown_q, penDown_d;
   logic       penUp_q, penUp_d;
   logic [3:0] cntInc, missInc;

   // The detector is asynchronous, so it crosses through two flops before use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weMeta_q <= 1'b0;
         penS_q   <= 1'b0;
      end else begin
         weMeta_q <= we;
         penS_q   <= weMeta_q;
      end
   end

   // Scan info is delayed so that it lines up with the pen response at penS_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
      end else if (!en) begin
         for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
      end else begin
         dl_q[0] <= {frame_start, pix_valid, pix_x, pix_y};
         for (int i = 1; i < DEPTH; i++) dl_q[i] <= dl_q[i-1];
      end
   end

   assign dFs    = dl_q[DEPTH-1][7];
   assign dPv    = dl_q[DEPTH-1][6];
   assign dX     = dl_q[DEPTH-1][5:3];
   assign dY     = dl_q[DEPTH-1][2:0];
   assign penHit = dPv & penS_q;

   assign cntInc  = (cnt_q  == 4'hF) ? cnt_q  : cnt_q  + 4'd1;
   assign missInc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_UP;
         frameOpen_q <= 1'b0;
         hit_q       <= 1'b0;
         hitX_q      <= '0;
         hitY_q      <= '0;
         candX_q     <= '0;
         candY_q     <= '0;
         cnt_q       <= '0;
         miss_q      <= '0;
         posX_q      <= '0;
         posY_q      <= '0;
         posValid_q  <= 1'b0;
         penDown_q   <= 1'b0;
         penUp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         frameOpen_q <= frameOpen_d;
         hit_q       <= hit_d;
         hitX_q      <= hitX_d;
         hitY_q      <= hitY_d;
         candX_q     <= candX_d;
         candY_q     <= candY_d;
         cnt_q       <= cnt_d;
         miss_q      <= miss_d;
         posX_q      <= posX_d;
         posY_q      <= posY_d;
         posValid_q  <= posValid_d;
         penDown_q   <= penDown_d;
         penUp_q     <= penUp_d;
      end
   end

   // A frame is judged only when the next frame start arrives; the hit in that same
   // cycle already belongs to the new frame.
   always_comb begin
      state_d     = state_q;
      frameOpen_d = frameOpen_q;
      hit_d       = hit_q;
      hitX_d      = hitX_q;
      hitY_d      = hitY_q;
      candX_d     = candX_q;
      candY_d     = candY_q;
      cnt_d       = cnt_q;
      miss_d      = miss_q;
      posX_d      = posX_q;
      posY_d      = posY_q;
      posValid_d  = 1'b0;
      penDown_d   = penDown_q;
      penUp_d     = 1'b0;

      if (!en) begin
         state_d     = ST_UP;
         frameOpen_d = 1'b0;
         hit_d       = 1'b0;
         cnt_d       = '0;
         miss_d      = '0;
         penDown_d   = 1'b0;
         penUp_d     = penDown_q;
      end else if (dFs) begin
         if (frameOpen_q) begin
            case (state_q)
               ST_UP: begin
                  if (hit_q) begin
                     candX_d = hitX_q;
                     candY_d = hitY_q;
                     cnt_d   = 4'd1;
                     if (CONFIRM_C <= 4'd1) begin
                        state_d    = ST_DOWN;
                        posX_d     = hitX_q;
                        posY_d     = hitY_q;
                        posValid_d = 1'b1;
                        penDown_d  = 1'b1;
                        miss_d     = '0;
                     end else begin
                        state_d = ST_ARMING;
                     end
                  end
               end
               ST_ARMING: begin
                  if (!hit_q) begin
                     state_d = ST_UP;
                     cnt_d   = '0;
                  end else if (hitX_q == candX_q && hitY_q == candY_q) begin
                     cnt_d = cntInc;
                     if (cntInc >= CONFIRM_C) begin
                        state_d    = ST_DOWN;
                        posX_d     = candX_q;
                        posY_d     = candY_q;
                        posValid_d = 1'b1;
                        penDown_d  = 1'b1;
                        miss_d     = '0;
                     end
                  end else begin
                     candX_d = hitX_q;
                     candY_d = hitY_q;
                     cnt_d   = 4'd1;
                  end
               end
               ST_DOWN: begin
                  if (hit_q) begin
                     miss_d = '0;
                     if (hitX_q != posX_q || hitY_q != posY_q) begin
                        posX_d     = hitX_q;
                        posY_d     = hitY_q;
                        posValid_d = 1'b1;
                     end
                  end else if (missInc >= MISS_C) begin
                     state_d   = ST_UP;
                     miss_d    = '0;
                     cnt_d     = '0;
                     penDown_d = 1'b0;
                     penUp_d   = 1'b1;
                  end else begin
                     miss_d = missInc;
                  end
               end
               default: state_d = ST_UP;
            endcase
         end
         frameOpen_d = 1'b1;
         hit_d       = penHit;
         if (penHit) begin
            hitX_d = dX;
            hitY_d = dY;
         end
      end else if (penHit && !hit_q) begin
         hit_d  = 1'b1;
         hitX_d = dX;
         hitY_d = dY;
      end
   end

   assign pos_x     = posX_q;
   assign pos_y     = posY_q;
   assign pos_valid = posValid_q;
   assign pen_down  = penDown_q;
   assign pen_up    = penUp_q;

endmodule

// File: tb/tb_lightpen_locator.sv
// Directed bench for lightpen_locator: scans the 8x8 matrix, models the pen response
// PEN_LAT cycles after the lit pixel, and checks position, pen-down and pen-up behaviour.
module tb_lightpen_locator;

   localparam int PEN_LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b1;
   logic       frame_start = 1'b0;
   logic       pix_valid = 1'b0;
   logic [2:0] pix_x = '0;
   logic [2:0] pix_y = '0;
   logic       we = 1'b0;
   logic [2:0] pos_x, pos_y;
   logic       pos_valid, pen_down, pen_up;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;
   int pvCount = 0;
   int upCount = 0;
   int pvCycle = 0;
   int lastFsCycle = 0;
   logic [2:0] pvX = '0, pvY = '0;
   logic [PEN_LAT-1:0] pend = '0;

   lightpen_locator #(.PEN_LAT(PEN_LAT), .CONFIRM_FRAMES(2), .MISS_FRAMES(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .we(we), .pos_x(pos_x), .pos_y(pos_y),
      .pos_valid(pos_valid), .pen_down(pen_down), .pen_up(pen_up)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulses are tallied on the falling edge so the scenario tasks can compare deltas.
   always @(negedge clk) begin
      if (pos_valid) begin
         pvCount++;
         pvCycle = cyc;
         pvX = pos_x;
         pvY = pos_y;
      end
      if (pen_up) upCount++;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic drive_slot(input logic fs, input logic pv, input logic [2:0] x,
                             input logic [2:0] y, input logic hit);
      @(posedge clk);
      #1;
      frame_start = fs;
      pix_valid   = pv;
      pix_x       = x;
      pix_y       = y;
      we          = pend[PEN_LAT-1];
      pend        = {pend[PEN_LAT-2:0], hit};
      if (fs) lastFsCycle = cyc;
   endtask

   // One pixel every other cycle in row-major order; the pen sees up to two pixels.
   task automatic run_frame(input int nSlots, input logic [2:0] ax, input logic [2:0] ay,
                            input logic aOn, input logic [2:0] bx, input logic [2:0] by,
                            input logic bOn);
      logic [2:0] x, y;
      logic hit;
      for (int s = 0; s < nSlots; s++) begin
         x = 3'(s % 8);
         y = 3'(s / 8);
         hit = (aOn && x == ax && y == ay) || (bOn && x == bx && y == by);
         drive_slot(s == 0, 1'b1, x, y, hit);
         drive_slot(1'b0, 1'b0, x, y, 1'b0);
      end
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      frame_start = 1'b0;
      pix_valid = 1'b0;
      we = 1'b0;
      pend = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int pv0;
      #1 rst_n = 1'b0;
      #2;
      testsRun++;
      if ({pos_x, pos_y, pos_valid, pen_down, pen_up} !== 9'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_initial: got %b expected 000000000",
                  {pos_x, pos_y, pos_valid, pen_down, pen_up});
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      run_frame(64, 3'd4, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(64, 3'd4, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(20, 3'd4, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b1 || pos_x !== 3'd4 || pos_y !== 3'd6) begin
         testsFailed++;
         $display("[TB] FAIL reset_pre_down: got down=%b pos=(%0d,%0d) expected down=1 pos=(4,6)",
                  pen_down, pos_x, pos_y);
      end
      we = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      testsRun++;
      if ({pos_x, pos_y, pos_valid, pen_down, pen_up} !== 9'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_async_clear: got %b expected 000000000",
                  {pos_x, pos_y, pos_valid, pen_down, pen_up});
      end
      pend = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      pv0 = pvCount;
      run_frame(64, 3'd4, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(64, 3'd4, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0 || pen_down !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_first_frame: got pulses=%0d down=%b expected pulses=0 down=0",
                  pvCount - pv0, pen_down);
      end
      run_frame(10, 3'd4, 3'd6, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b1 || pvCount != pv0 + 1) begin
         testsFailed++;
         $display("[TB] FAIL reset_resume: got down=%b pulses=%0d expected down=1 pulses=1",
                  pen_down, pvCount - pv0);
      end
   endtask

   task automatic test_confirm();
      int pv0;
      resetDut();
      pv0 = pvCount;
      run_frame(64, 3'd5, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(64, 3'd5, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b0 || pvCount != pv0) begin
         testsFailed++;
         $display("[TB] FAIL confirm_early: got down=%b pulses=%0d expected down=0 pulses=0",
                  pen_down, pvCount - pv0);
      end
      run_frame(64, 3'd5, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0 + 1 || pvX !== 3'd5 || pvY !== 3'd2 || pen_down !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL confirm_pos: got pulses=%0d pos=(%0d,%0d) down=%b expected pulses=1 pos=(5,2) down=1",
                  pvCount - pv0, pvX, pvY, pen_down);
      end
      testsRun++;
      if (pvCycle != lastFsCycle + PEN_LAT + 3) begin
         testsFailed++;
         $display("[TB] FAIL confirm_timing: got cycle %0d expected %0d", pvCycle,
                  lastFsCycle + PEN_LAT + 3);
      end
   endtask

   task automatic test_drag();
      int pv0;
      pv0 = pvCount;
      run_frame(64, 3'd6, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0) begin
         testsFailed++;
         $display("[TB] FAIL drag_same: got pulses=%0d expected 0", pvCount - pv0);
      end
      run_frame(64, 3'd6, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0 + 1 || pos_x !== 3'd6 || pos_y !== 3'd2) begin
         testsFailed++;
         $display("[TB] FAIL drag_move: got pulses=%0d pos=(%0d,%0d) expected pulses=1 pos=(6,2)",
                  pvCount - pv0, pos_x, pos_y);
      end
      run_frame(64, 3'd6, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0 + 1) begin
         testsFailed++;
         $display("[TB] FAIL drag_repeat: got pulses=%0d expected 1", pvCount - pv0);
      end
   endtask

   task automatic test_lift();
      int pv0, up0;
      pv0 = pvCount;
      up0 = upCount;
      repeat (3) run_frame(64, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b1 || upCount != up0) begin
         testsFailed++;
         $display("[TB] FAIL lift_two_miss: got down=%b ups=%0d expected down=1 ups=0",
                  pen_down, upCount - up0);
      end
      run_frame(64, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b0 || upCount != up0 + 1 || pvCount != pv0) begin
         testsFailed++;
         $display("[TB] FAIL lift_third_miss: got down=%b ups=%0d pulses=%0d expected down=0 ups=1 pulses=0",
                  pen_down, upCount - up0, pvCount - pv0);
      end
      testsRun++;
      if (pos_x !== 3'd6 || pos_y !== 3'd2) begin
         testsFailed++;
         $display("[TB] FAIL lift_pos_hold: got (%0d,%0d) expected (6,2)", pos_x, pos_y);
      end
   endtask

   task automatic test_jitter();
      int pv0;
      resetDut();
      pv0 = pvCount;
      run_frame(64, 3'd1, 3'd1, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(64, 3'd3, 3'd3, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(64, 3'd3, 3'd3, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b0 || pvCount != pv0) begin
         testsFailed++;
         $display("[TB] FAIL jitter_no_confirm: got down=%b pulses=%0d expected down=0 pulses=0",
                  pen_down, pvCount - pv0);
      end
      run_frame(64, 3'd0, 3'd4, 1'b1, 3'd7, 3'd7, 1'b1);
      testsRun++;
      if (pvCount != pv0 + 1 || pvX !== 3'd3 || pvY !== 3'd3 || pen_down !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL jitter_confirm: got pulses=%0d pos=(%0d,%0d) down=%b expected pulses=1 pos=(3,3) down=1",
                  pvCount - pv0, pvX, pvY, pen_down);
      end
      run_frame(64, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0 + 2 || pos_x !== 3'd0 || pos_y !== 3'd4) begin
         testsFailed++;
         $display("[TB] FAIL multi_hit_first: got pulses=%0d pos=(%0d,%0d) expected pulses=2 pos=(0,4)",
                  pvCount - pv0, pos_x, pos_y);
      end
   endtask

   task automatic test_abort();
      int pv0, up0;
      pv0 = pvCount;
      up0 = upCount;
      @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk);
      #1;
      testsRun++;
      if (pen_up !== 1'b1 || pen_down !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL abort_pen_up: got up=%b down=%b expected up=1 down=0", pen_up, pen_down);
      end
      @(posedge clk);
      #1;
      testsRun++;
      if (pen_up !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL abort_single_pulse: got up=%b expected 0", pen_up);
      end
      repeat (3) run_frame(64, 3'd2, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pvCount != pv0 || pen_down !== 1'b0 || upCount != up0 + 1 ||
          pos_x !== 3'd0 || pos_y !== 3'd4) begin
         testsFailed++;
         $display("[TB] FAIL abort_ignored: got pulses=%0d ups=%0d down=%b pos=(%0d,%0d) expected pulses=0 ups=1 down=0 pos=(0,4)",
                  pvCount - pv0, upCount - up0, pen_down, pos_x, pos_y);
      end
      en = 1'b1;
      run_frame(64, 3'd2, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      run_frame(64, 3'd2, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b0 || pvCount != pv0) begin
         testsFailed++;
         $display("[TB] FAIL abort_rearm: got down=%b pulses=%0d expected down=0 pulses=0",
                  pen_down, pvCount - pv0);
      end
      run_frame(64, 3'd2, 3'd2, 1'b1, 3'd0, 3'd0, 1'b0);
      testsRun++;
      if (pen_down !== 1'b1 || pvCount != pv0 + 1 || pos_x !== 3'd2 || pos_y !== 3'd2) begin
         testsFailed++;
         $display("[TB] FAIL abort_reconfirm: got down=%b pulses=%0d pos=(%0d,%0d) expected down=1 pulses=1 pos=(2,2)",
                  pen_down, pvCount - pv0, pos_x, pos_y);
      end
   endtask

   initial begin
      test_reset();
      test_confirm();
      test_drag();
      test_lift();
      test_jitter();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
